// File: rtl/bound_flasher_pkg.sv
// Shared definitions for the bound flasher: phase encoding, per-phase lamp targets
// and the kickback re-entry points.
package bound_flasher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UP1   = 3'd1,
        ST_DOWN1 = 3'd2,
        ST_UP2   = 3'd3,
        ST_DOWN2 = 3'd4,
        ST_UP3   = 3'd5,
        ST_DOWN3 = 3'd6
    } state_t;

    localparam int unsigned LAMP_MAX  = 32'd16;
    localparam int unsigned TGT_UP1   = 32'd16;
    localparam int unsigned TGT_DOWN1 = 32'd5;
    localparam int unsigned TGT_UP2   = 32'd11;
    localparam int unsigned TGT_DOWN2 = 32'd0;
    localparam int unsigned TGT_UP3   = 32'd6;
    localparam int unsigned TGT_DOWN3 = 32'd0;

    localparam int unsigned KICK_DOWN1_AT  = 32'd5;
    localparam int unsigned KICK_DOWN2_MID = 32'd5;
    localparam int unsigned KICK_DOWN2_END = 32'd0;

    function automatic int unsigned target_of(input state_t s);
        case (s)
            ST_UP1:   return TGT_UP1;
            ST_DOWN1: return TGT_DOWN1;
            ST_UP2:   return TGT_UP2;
            ST_DOWN2: return TGT_DOWN2;
            ST_UP3:   return TGT_UP3;
            ST_DOWN3: return TGT_DOWN3;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic is_up(input state_t s);
        return (s == ST_UP1) || (s == ST_UP2) || (s == ST_UP3);
    endfunction

    function automatic state_t next_phase(input state_t s);
        case (s)
            ST_UP1:   return ST_DOWN1;
            ST_DOWN1: return ST_UP2;
            ST_UP2:   return ST_DOWN2;
            ST_DOWN2: return ST_UP3;
            ST_UP3:   return ST_DOWN3;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/bound_flasher_ctrl_edge_detect.sv
// Rising-edge detector for the user request; the history flop resets high so a
// level already present at reset release is not mistaken for a new request.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_d;
    logic sig_q;

    // history input
    always_comb begin
        sig_d = sig;
    end

    // history register
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig_d;
        end
    end

    // edge output
    always_comb begin
        rise = sig & ~sig_q;
    end

endmodule

// File: rtl/bound_flasher_ctrl.sv
// Bound flasher sequencer: sweeps lamp_cnt 0->16->5->11->0->6->0 one step per tick.
// Optional kickback (flick during DOWN1/DOWN2 re-enters an UP phase) is built only
// when BOUND_FLASHER_KICKBACK_EN is defined.
module bound_flasher_ctrl
    import bound_flasher_pkg::*;
#(
    parameter int CNT_W    = 5,
    parameter int STEP_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flick,
    output logic [CNT_W-1:0] lamp_cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0]       PRESC_LAST = 8'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] LAMP_TOP   = CNT_W'(LAMP_MAX);
    localparam logic [CNT_W-1:0] LAMP_ZERO  = {CNT_W{1'b0}};

    state_t           state_q, state_d, kick_state_s;
    logic [CNT_W-1:0] lamp_cnt_q, lamp_cnt_d, tgt_s;
    logic [7:0]       presc_q, presc_d;
    logic             done_q, done_d;
    logic             start_s, tick_s, at_tgt_s, kick_s;

    edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (flick),
        .rise (start_s)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lamp_cnt_q <= LAMP_ZERO;
            presc_q    <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lamp_cnt_q <= lamp_cnt_d;
            presc_q    <= presc_d;
            done_q     <= done_d;
        end
    end

    // next-state, counter and prescaler logic
    always_comb begin
        tgt_s        = CNT_W'(target_of(state_q));
        at_tgt_s     = (lamp_cnt_q == tgt_s);
        tick_s       = (state_q != ST_IDLE) && (presc_q == PRESC_LAST);
        kick_s       = 1'b0;
        kick_state_s = state_q;
`ifdef BOUND_FLASHER_KICKBACK_EN
        if (flick && (state_q == ST_DOWN1) && (lamp_cnt_q == CNT_W'(KICK_DOWN1_AT))) begin
            kick_s       = 1'b1;
            kick_state_s = ST_UP1;
        end else if (flick && (state_q == ST_DOWN2) &&
                     ((lamp_cnt_q == CNT_W'(KICK_DOWN2_MID)) ||
                      (lamp_cnt_q == CNT_W'(KICK_DOWN2_END)))) begin
            kick_s       = 1'b1;
            kick_state_s = ST_UP2;
        end else begin
            kick_s       = 1'b0;
            kick_state_s = state_q;
        end
`endif
        state_d    = state_q;
        lamp_cnt_d = lamp_cnt_q;
        done_d     = 1'b0;
        // entry into UP1 always happens from IDLE or on a tick, so this also clears it there
        if ((state_q == ST_IDLE) || tick_s) begin
            presc_d = 8'd0;
        end else begin
            presc_d = presc_q + 8'd1;
        end
        case (state_q)
            ST_IDLE: begin
                lamp_cnt_d = LAMP_ZERO;
                if (start_s) begin
                    state_d = ST_UP1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (!tick_s) begin
                    state_d = state_q;
                end else if (kick_s) begin
                    state_d = kick_state_s;
                end else if (at_tgt_s) begin
                    state_d = next_phase(state_q);
                    done_d  = (state_q == ST_DOWN3);
                end else if (is_up(state_q)) begin
                    if (lamp_cnt_q < LAMP_TOP) begin
                        lamp_cnt_d = lamp_cnt_q + CNT_W'(1);
                    end else begin
                        lamp_cnt_d = lamp_cnt_q;
                    end
                end else begin
                    if (lamp_cnt_q != LAMP_ZERO) begin
                        lamp_cnt_d = lamp_cnt_q - CNT_W'(1);
                    end else begin
                        lamp_cnt_d = lamp_cnt_q;
                    end
                end
            end
        endcase
    end

    // outputs
    always_comb begin
        lamp_cnt = lamp_cnt_q;
        busy     = (state_q != ST_IDLE);
        done     = done_q;
    end

endmodule
